// File: rtl/xaps_tpl_pkg.sv
// xaps_tpl_pkg: shared record type, field selects, FSM states and reset defaults for the template engine
package xaps_tpl_pkg;
  typedef struct packed {
    logic [31:0] min_rel;
    logic [31:0] max_lat;
    logic [31:0] power;
    logic [31:0] redundancy;
    logic [31:0] mon_freq;
    logic        valid;
  } tpl_rec_t;
  localparam logic [2:0] F_MIN_REL = 3'd0;
  localparam logic [2:0] F_MAX_LAT = 3'd1;
  localparam logic [2:0] F_POWER = 3'd2;
  localparam logic [2:0] F_REDUNDANCY = 3'd3;
  localparam logic [2:0] F_MON_FREQ = 3'd4;
  localparam logic [2:0] F_VALID = 3'd5;
  localparam int NUM_BEATS = 7;
  typedef enum logic [1:0] {IDLE, LOOKUP, STREAM, RESP} state_t;
  localparam tpl_rec_t [0:3] DEFAULT_TPL = '{
    '{32'd9999, 32'd1000, 32'd10000, 32'd2, 32'd10, 1'b1},
    '{32'd99999, 32'd100, 32'd5000, 32'd3, 32'd100, 1'b1},
    '{32'd9999, 32'd10, 32'd100, 32'd1, 32'd1000, 1'b1},
    '{32'd999999, 32'd1, 32'd50, 32'd2, 32'd1000, 1'b1}
  };
  function automatic logic [31:0] beat_word(input logic [159:0] f, input logic [31:0] cid,
                                            input logic [31:0] ty, input logic [2:0] b);
    return b == 3'd0 ? cid :
           b == 3'd1 ? ty :
           b == 3'd2 ? f[159:128] :
           b == 3'd3 ? f[127:96] :
           b == 3'd4 ? f[95:64] :
           b == 3'd5 ? f[63:32] : f[31:0];
  endfunction
endpackage

// File: rtl/xaps_template_engine_fifo.sv
// xaps_req_fifo: synchronous power-of-two request FIFO with occupancy count
module xaps_req_fifo #(
  parameter int DEPTH = 4,
  parameter int W = 40
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    push,
  input  logic                    pop,
  input  logic [W-1:0]            din,
  output logic [W-1:0]            dout,
  output logic                    full,
  output logic                    empty,
  output logic [$clog2(DEPTH):0]  level
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_LVL = DEPTH[AW:0];
  logic [W-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic do_push, do_pop;
  assign full = level == FULL_LVL;
  assign empty = level == '0;
  assign do_push = push && !full;
  assign do_pop = pop && !empty;
  assign dout = mem[rd_ptr];
  always_ff @(posedge clk) if (do_push) mem[wr_ptr] <= din;
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level <= '0;
    end else begin
      wr_ptr <= wr_ptr + AW'(do_push);
      rd_ptr <= rd_ptr + AW'(do_pop);
      level <= level + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  end
endmodule

// File: rtl/xaps_template_engine.sv
// xaps_template_engine: programmable template table, request FIFO, lookup FSM and XR-BUS beat stream
module xaps_template_engine
  import xaps_tpl_pkg::*;
#(
  parameter int N_TPL = 8,
  parameter int FIFO_DEPTH = 4,
  parameter int TYPE_W = 8
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         req_valid,
  output logic                         req_ready,
  input  logic [TYPE_W-1:0]            req_type,
  input  logic [31:0]                  req_cid,
  input  logic                         cfg_we,
  input  logic [$clog2(N_TPL)-1:0]     cfg_idx,
  input  logic [2:0]                   cfg_field,
  input  logic [31:0]                  cfg_data,
  output logic                         xb_valid,
  input  logic                         xb_ready,
  output logic [31:0]                  xb_data,
  output logic                         xb_last,
  output logic                         rsp_valid,
  input  logic                         rsp_ready,
  output logic [191:0]                 rsp_params,
  output logic                         rsp_err,
  output logic [$clog2(FIFO_DEPTH):0]  fifo_level,
  output logic [15:0]                  err_cnt
);
  localparam int IW = $clog2(N_TPL);
  tpl_rec_t tbl [N_TPL];
  state_t state, state_d;
  logic [TYPE_W+31:0] head;
  logic [TYPE_W-1:0] cur_type;
  logic [31:0] cur_cid;
  logic [159:0] rec_f;
  logic [2:0] beat;
  logic full, empty, pop, err, xb_fire;
  xaps_req_fifo #(.DEPTH(FIFO_DEPTH), .W(TYPE_W + 32)) u_fifo (
    .clk(clk),
    .rst(rst),
    .push(req_valid && req_ready),
    .pop(pop),
    .din({req_type, req_cid}),
    .dout(head),
    .full(full),
    .empty(empty),
    .level(fifo_level)
  );
  assign req_ready = !full;
  assign pop = state == IDLE && !empty;
  assign err = 32'(cur_type) >= N_TPL || !tbl[cur_type[IW-1:0]].valid;
  assign xb_valid = state == STREAM;
  assign xb_fire = xb_valid && xb_ready;
  assign xb_last = xb_valid && beat == 3'(NUM_BEATS - 1);
  assign xb_data = xb_valid ? beat_word(rec_f, cur_cid, 32'(cur_type), beat) : '0;
  assign rsp_valid = state == RESP;
  assign rsp_params = {rec_f, cur_cid};
  always_ff @(posedge clk) state <= rst ? IDLE : state_d;
  always_comb begin
    state_d = state;
    case (state)
      IDLE:    state_d = empty ? IDLE : LOOKUP;
      LOOKUP:  state_d = err ? RESP : STREAM;
      STREAM:  state_d = xb_last && xb_ready ? RESP : STREAM;
      RESP:    state_d = rsp_ready ? IDLE : RESP;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      cur_type <= '0;
      cur_cid <= '0;
      rec_f <= '0;
      rsp_err <= 1'b0;
      err_cnt <= '0;
      beat <= '0;
    end else begin
      if (pop) {cur_type, cur_cid} <= head;
      if (state == LOOKUP) begin
        rec_f <= err ? '0 : tbl[cur_type[IW-1:0]][160:1];
        rsp_err <= err;
        beat <= '0;
        if (err) err_cnt <= err_cnt + 16'(err_cnt != 16'hFFFF);
      end
      if (xb_fire) beat <= beat + 3'd1;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < N_TPL; i++) tbl[i] <= i < 4 ? DEFAULT_TPL[2'(i)] : '0;
    end else if (cfg_we) begin
      case (cfg_field)
        F_MIN_REL:    tbl[cfg_idx].min_rel <= cfg_data;
        F_MAX_LAT:    tbl[cfg_idx].max_lat <= cfg_data;
        F_POWER:      tbl[cfg_idx].power <= cfg_data;
        F_REDUNDANCY: tbl[cfg_idx].redundancy <= cfg_data;
        F_MON_FREQ:   tbl[cfg_idx].mon_freq <= cfg_data;
        F_VALID:      tbl[cfg_idx].valid <= cfg_data[0];
        default:      ;
      endcase
    end
  end
endmodule

// File: tb/tb_xaps_template_engine.sv
// tb_xaps_template_engine: directed and randomized requests checked against a behavioural template table model
module tb_xaps_template_engine;
  localparam int N_TPL = 8;
  localparam int FIFO_DEPTH = 4;
  localparam int TYPE_W = 8;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic req_valid = 1'b0;
  logic req_ready;
  logic [TYPE_W-1:0] req_type = '0;
  logic [31:0] req_cid = '0;
  logic cfg_we = 1'b0;
  logic [2:0] cfg_idx = '0;
  logic [2:0] cfg_field = '0;
  logic [31:0] cfg_data = '0;
  logic xb_valid, xb_last;
  logic xb_ready = 1'b1;
  logic [31:0] xb_data;
  logic rsp_valid, rsp_err;
  logic rsp_ready = 1'b1;
  logic [191:0] rsp_params;
  logic [2:0] fifo_level;
  logic [15:0] err_cnt;
  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int m_err = 0;
  logic [159:0] m_rec [N_TPL];
  bit m_v [N_TPL];
  int q_ty [5];
  logic [31:0] q_cid [5];
  logic [160:0] q_e [5];
  int tys [6] = '{0, 1, 2, 3, 5, 9};
  int p;
  bit saw;
  xaps_template_engine #(.N_TPL(N_TPL), .FIFO_DEPTH(FIFO_DEPTH), .TYPE_W(TYPE_W)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready), .req_type(req_type),
    .req_cid(req_cid), .cfg_we(cfg_we), .cfg_idx(cfg_idx), .cfg_field(cfg_field), .cfg_data(cfg_data),
    .xb_valid(xb_valid), .xb_ready(xb_ready), .xb_data(xb_data), .xb_last(xb_last),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_params(rsp_params), .rsp_err(rsp_err),
    .fifo_level(fifo_level), .err_cnt(err_cnt)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic check(input string tag, input logic [191:0] got, input logic [191:0] want);
    checks++;
    assert (got === want) else begin
      failures++;
      $error("FAIL %s: got %0h expected %0h", tag, got, want);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  function automatic void model_reset();
    for (int i = 0; i < N_TPL; i++) begin
      m_rec[i] = '0;
      m_v[i] = 1'b0;
    end
    m_rec[0] = {32'd9999, 32'd1000, 32'd10000, 32'd2, 32'd10};
    m_rec[1] = {32'd99999, 32'd100, 32'd5000, 32'd3, 32'd100};
    m_rec[2] = {32'd9999, 32'd10, 32'd100, 32'd1, 32'd1000};
    m_rec[3] = {32'd999999, 32'd1, 32'd50, 32'd2, 32'd1000};
    for (int i = 0; i < 4; i++) m_v[i] = 1'b1;
    m_err = 0;
  endfunction
  function automatic logic [160:0] snap(input int ty);
    if (ty >= N_TPL) return {1'b1, 160'b0};
    if (!m_v[ty]) return {1'b1, 160'b0};
    return {1'b0, m_rec[ty]};
  endfunction
  task automatic do_cfg(input int idx, input int field, input logic [31:0] data);
    cfg_we = 1'b1;
    cfg_idx = 3'(idx);
    cfg_field = 3'(field);
    cfg_data = data;
    step();
    cfg_we = 1'b0;
    if (field < 5) m_rec[idx][159-32*field -: 32] = data;
    else if (field == 5) m_v[idx] = data[0];
  endtask
  task automatic push_req(input int ty, input logic [31:0] cid, output int pe);
    req_valid = 1'b1;
    req_type = TYPE_W'(ty);
    req_cid = cid;
    for (int w = 0; w < 60 && !req_ready; w++) step();
    check("req_ready_wait", req_ready, 1);
    step();
    pe = cyc;
    req_valid = 1'b0;
  endtask
  task automatic stream_chk(input int ty, input logic [31:0] cid, input logic [159:0] ef,
                            input int pe, input int stall_at, input int stall_n);
    logic [31:0] want;
    for (int k = 0; k < 7; k++) begin
      if (k == 0) want = cid;
      else if (k == 1) want = 32'(ty);
      else want = ef[159-32*(k-2) -: 32];
      for (int w = 0; w < 60 && !xb_valid; w++) step();
      check("xb_valid_wait", xb_valid, 1);
      if (k == stall_at) begin
        xb_ready = 1'b0;
        for (int s = 0; s < stall_n; s++) begin
          if (s == 0) do_cfg(ty, int'($urandom_range(0, 4)), $urandom);
          else step();
          check("stall_data", xb_data, want);
          check("stall_valid", xb_valid, 1);
        end
        xb_ready = 1'b1;
      end
      check("beat_data", xb_data, want);
      check("beat_last", xb_last, k == 6);
      if (pe >= 0) check("beat_time", cyc + 1, pe + 3 + k);
      step();
    end
  endtask
  task automatic resp_chk(input logic [31:0] cid, input logic [160:0] e, input int pe);
    bit seen;
    seen = 1'b0;
    for (int w = 0; w < 60 && !rsp_valid; w++) begin
      seen |= xb_valid;
      step();
    end
    check("rsp_valid_wait", rsp_valid, 1);
    if (e[160]) check("err_no_stream", seen, 0);
    if (pe >= 0) check("rsp_time", cyc + 1, pe + (e[160] ? 3 : 10));
    check("rsp_err", rsp_err, e[160]);
    check("rsp_params", rsp_params, {e[159:0], cid});
    if (e[160]) m_err++;
    check("err_cnt", err_cnt, m_err);
    step();
    check("rsp_drop", rsp_valid, 0);
  endtask
  task automatic run_txn(input int ty, input logic [31:0] cid, input int stall_at, input int stall_n);
    logic [160:0] e;
    int pe;
    e = snap(ty);
    push_req(ty, cid, pe);
    if (stall_n != 0) pe = -1;
    if (!e[160]) stream_chk(ty, cid, e[159:0], pe, stall_at, stall_n);
    resp_chk(cid, e, pe);
  endtask
  initial begin
    model_reset();
    repeat (3) step();
    check("rst_xb_valid", xb_valid, 0);
    check("rst_xb_last", xb_last, 0);
    check("rst_xb_data", xb_data, 0);
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_rsp_err", rsp_err, 0);
    check("rst_rsp_params", rsp_params, 0);
    check("rst_fifo_level", fifo_level, 0);
    check("rst_err_cnt", err_cnt, 0);
    check("rst_req_ready", req_ready, 1);
    rst = 1'b0;
    step();
    run_txn(1, 32'hCAFE0001, 0, 0);
    run_txn(9, 32'h0BAD0009, 0, 0);
    for (int f = 0; f < 5; f++) do_cfg(5, f, 32'(f + 1));
    do_cfg(5, 5, 32'd1);
    run_txn(5, 32'h5EED0005, 0, 0);
    run_txn(1, 32'h57A11001, 2, 3);
    rsp_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      q_ty[i] = tys[$urandom_range(0, 5)];
      q_cid[i] = $urandom;
      q_e[i] = snap(q_ty[i]);
      push_req(q_ty[i], q_cid[i], p);
    end
    check("fifo_full_level", fifo_level, 4);
    check("fifo_full_ready", req_ready, 0);
    req_valid = 1'b1;
    req_type = '0;
    step();
    step();
    req_valid = 1'b0;
    check("fifo_no_overflow", fifo_level, 4);
    rsp_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      if (i > 0 && !q_e[i][160]) stream_chk(q_ty[i], q_cid[i], q_e[i][159:0], -1, 7, 0);
      resp_chk(q_cid[i], q_e[i], -1);
    end
    for (int it = 0; it < 12; it++) begin
      repeat ($urandom_range(0, 2)) do_cfg(int'($urandom_range(0, 7)), int'($urandom_range(0, 7)), $urandom);
      run_txn(int'($urandom_range(0, N_TPL + 1)), $urandom, int'($urandom_range(0, 6)), int'($urandom_range(0, 2)));
    end
    do_cfg(5, 5, 32'd1);
    push_req(5, 32'h5555_0005, p);
    push_req(0, 32'h1111_0000, p);
    for (int w = 0; w < 60 && !xb_valid; w++) step();
    step();
    check("pre_reset_stream", xb_valid, 1);
    check("pre_reset_level", fifo_level, 1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    model_reset();
    check("mid_rst_xb_valid", xb_valid, 0);
    check("mid_rst_xb_last", xb_last, 0);
    check("mid_rst_fifo_level", fifo_level, 0);
    check("mid_rst_rsp_valid", rsp_valid, 0);
    check("mid_rst_err_cnt", err_cnt, 0);
    saw = 1'b0;
    repeat (12) begin
      saw |= xb_valid | rsp_valid;
      step();
    end
    check("post_rst_idle", saw, 0);
    run_txn(5, 32'hDEAD0005, 0, 0);
    run_txn(3, 32'hF00D0003, 0, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
